// File: rtl/mem_dma_copy_if.sv
// Command and memory-bus signal bundle for the mem_dma_copy bus initiator.
// master = the copy engine, slave = command source plus memory unit.
interface mem_dma_copy_if;
  logic [26:0] cmd_src;
  logic [26:0] cmd_dst;
  logic [15:0] cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        abort;
  logic        done;
  logic [1:0]  status;
  logic [15:0] words_done;
  logic [26:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic        bus_start;
  logic        bus_busy;
  logic [31:0] bus_q;
  logic        bus_initDone;

  modport master (
    input  cmd_src, cmd_dst, cmd_len, cmd_valid, abort,
    input  bus_busy, bus_q, bus_initDone,
    output cmd_ready, done, status, words_done,
    output bus_addr, bus_data, bus_we, bus_start
  );

  modport slave (
    output cmd_src, cmd_dst, cmd_len, cmd_valid, abort,
    output bus_busy, bus_q, bus_initDone,
    input  cmd_ready, done, status, words_done,
    input  bus_addr, bus_data, bus_we, bus_start
  );
endinterface

// File: rtl/mem_dma_copy.sv
// Word-by-word memory copy engine on the MemoryUnit start/busy bus:
// one read then one write per word, with per-transaction timeout and abort.
module mem_dma_copy #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  mem_dma_copy_if.master io
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_GAP_W, S_WRITE, S_GAP_R, S_FINISH
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  state_e      state_q, state_d;
  logic [26:0] src_q, src_d;
  logic [26:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic        seen_q, seen_d;
  logic [31:0] tmo_q, tmo_d;
  logic        abort_q, abort_d;
  logic [1:0]  status_q, status_d;
  logic        done_q, done_d;
  logic [26:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        start_q, start_d;

  logic        complete;
  logic        tmo_hit;
  logic        accept;
  logic [15:0] idx_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
      seen_q   <= 1'b0;
      tmo_q    <= '0;
      abort_q  <= 1'b0;
      status_q <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      seen_q   <= seen_d;
      tmo_q    <= tmo_d;
      abort_q  <= abort_d;
      status_q <= status_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      start_q  <= start_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    seen_d   = seen_q;
    tmo_d    = tmo_q;
    abort_d  = abort_q;
    status_d = status_q;
    done_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    start_d  = start_q;

    accept   = io.cmd_valid && (state_q == S_IDLE) && io.bus_initDone;
    complete = seen_q && !io.bus_busy;
    tmo_hit  = (TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT - 1));
    idx_inc  = idx_q + 16'd1;

    // A short abort pulse is remembered so it is honoured at the next word boundary.
    if (state_q != S_IDLE) abort_d = abort_q | io.abort;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          src_d    = io.cmd_src;
          dst_d    = io.cmd_dst;
          len_d    = io.cmd_len;
          idx_d    = '0;
          status_d = ST_OK;
          abort_d  = 1'b0;
          if (io.cmd_len == 16'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_READ;
            addr_d  = io.cmd_src;
            we_d    = 1'b0;
            data_d  = '0;
            start_d = 1'b1;
            seen_d  = 1'b0;
            tmo_d   = '0;
          end
        end
      end
      S_READ, S_WRITE: begin
        seen_d = seen_q | io.bus_busy;
        if (complete) begin
          start_d = 1'b0;
          seen_d  = 1'b0;
          if (state_q == S_READ) begin
            buf_d   = io.bus_q;
            state_d = S_GAP_W;
          end else begin
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
              state_d = S_FINISH;
            end else if (abort_q || io.abort) begin
              status_d = ST_ABORT;
              state_d  = S_FINISH;
            end else begin
              state_d = S_GAP_R;
            end
          end
        end else if (tmo_hit) begin
          start_d  = 1'b0;
          seen_d   = 1'b0;
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_GAP_W: begin
        state_d = S_WRITE;
        addr_d  = dst_q + 27'(idx_q);
        we_d    = 1'b1;
        data_d  = buf_q;
        start_d = 1'b1;
        tmo_d   = '0;
      end
      S_GAP_R: begin
        state_d = S_READ;
        addr_d  = src_q + 27'(idx_q);
        we_d    = 1'b0;
        data_d  = '0;
        start_d = 1'b1;
        tmo_d   = '0;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.cmd_ready  = (state_q == S_IDLE) && io.bus_initDone;
    io.done       = done_q;
    io.status     = status_q;
    io.words_done = idx_q;
    io.bus_addr   = addr_q;
    io.bus_data   = data_q;
    io.bus_we     = we_q;
    io.bus_start  = start_q;
  end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Self-checking bench for mem_dma_copy: behavioural memory unit with
// configurable busy timing and a transaction scoreboard.
module tb_mem_dma_copy;
  localparam int TMO = 16;

  logic clk;
  logic reset;
  mem_dma_copy_if io ();

  mem_dma_copy #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int fail_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [26:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t exp_q[$];

  bit [31:0] mem [bit [26:0]];

  function automatic logic [31:0] pattern(input logic [26:0] a);
    return {5'h15, a};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [26:0] a);
    if (mem.exists(a)) return mem[a];
    return pattern(a);
  endfunction

  task automatic push_copy(input logic [26:0] src, input logic [26:0] dst,
                           input int n, input int extra_rd);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      t.we = 1'b0; t.addr = src + 27'(i); t.data = '0;              exp_q.push_back(t);
      t.we = 1'b1; t.addr = dst + 27'(i); t.data = mem_rd(src + 27'(i)); exp_q.push_back(t);
    end
    for (int i = 0; i < extra_rd; i++) begin
      t.we = 1'b0; t.addr = src + 27'(n + i); t.data = '0; exp_q.push_back(t);
    end
  endtask

  // ---------------- memory unit model ----------------
  int txn_cnt  = 0;
  int pre_dly  = 0;
  int busy_len = 1;
  int hang_txn = -1;
  logic [26:0] m_addr;
  logic        m_we;
  logic [31:0] m_data;

  task automatic stab();
    if (reset) begin
      check_eq("hold_start", io.bus_start, 1'b1);
      check_eq("hold_addr", io.bus_addr, m_addr);
      check_eq("hold_we", io.bus_we, m_we);
      check_eq("hold_data", io.bus_data, m_data);
    end
  endtask

  initial begin : mem_model
    txn_t e;
    io.bus_busy = 1'b0;
    io.bus_q    = '0;
    forever begin
      @(negedge clk);
      if (io.bus_start && reset) begin
        txn_cnt++;
        m_addr = io.bus_addr;
        m_we   = io.bus_we;
        m_data = io.bus_data;
        check_eq("sb_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_we", m_we, e.we);
          check_eq("sb_addr", m_addr, e.addr);
          check_eq("sb_data", m_data, e.data);
        end
        if (txn_cnt == hang_txn) begin
          for (int i = 0; i < TMO + 4 && io.bus_start; i++) @(negedge clk);
          check_eq("tmo_release", io.bus_start, 1'b0);
        end else begin
          for (int i = 0; i < pre_dly; i++) begin @(negedge clk); stab(); end
          io.bus_busy = 1'b1;
          for (int i = 0; i < busy_len; i++) begin @(negedge clk); stab(); end
          if (m_we) mem[m_addr] = m_data;
          else      io.bus_q = mem_rd(m_addr);
          io.bus_busy = 1'b0;
          for (int i = 0; i < 4 && io.bus_start; i++) @(negedge clk);
          check_eq("start_release", io.bus_start, 1'b0);
        end
      end
    end
  end

  // ---------------- start monitor ----------------
  int   start_cnt = 0;
  int   hi_cnt    = 0;
  int   last_hi   = 0;
  logic prev_start = 1'b0;

  initial begin : start_mon
    forever begin
      @(negedge clk);
      if (io.bus_start && !prev_start) start_cnt++;
      if (io.bus_start) hi_cnt++;
      else if (prev_start) begin last_hi = hi_cnt; hi_cnt = 0; end
      prev_start = io.bus_start;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [26:0] src, input logic [26:0] dst,
                         input logic [15:0] len, output int cyc);
    @(negedge clk);
    check_eq("cmd_ready", io.cmd_ready, 1'b1);
    start_cnt    = 0;
    io.cmd_src   = src;
    io.cmd_dst   = dst;
    io.cmd_len   = len;
    io.cmd_valid = 1'b1;
    @(negedge clk);
    io.cmd_valid = 1'b0;
    cyc = 1;
    while (!io.done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_seen", io.done, 1'b1);
    @(negedge clk);
    check_eq("done_pulse", io.done, 1'b0);
  endtask

  int cyc;
  int base;

  initial begin : stim
    reset           = 1'b0;
    io.bus_initDone = 1'b0;
    io.cmd_valid    = 1'b0;
    io.cmd_src      = '0;
    io.cmd_dst      = '0;
    io.cmd_len      = '0;
    io.abort        = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_start", io.bus_start, 1'b0);
    check_eq("rst_done", io.done, 1'b0);
    check_eq("rst_status", io.status, 2'b00);
    check_eq("rst_words", io.words_done, 16'd0);
    check_eq("rst_addr", io.bus_addr, 27'd0);
    check_eq("rst_we", io.bus_we, 1'b0);
    check_eq("rst_data", io.bus_data, 32'd0);
    check_eq("rst_ready_noinit", io.cmd_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_noinit", io.cmd_ready, 1'b0);
    io.bus_initDone = 1'b1;
    #1 check_eq("ready_init", io.cmd_ready, 1'b1);

    // zero-length command
    run_cmd(27'h0, 27'h100, 16'd0, cyc);
    check_eq("len0_latency", cyc, 2);
    check_eq("len0_starts", start_cnt, 0);
    check_eq("len0_status", io.status, 2'b00);
    check_eq("len0_words", io.words_done, 16'd0);

    // VRAM32-like timing, 4 words
    push_copy(27'hC00000, 27'h100, 4, 0);
    run_cmd(27'hC00000, 27'h100, 16'd4, cyc);
    check_eq("vram_starts", start_cnt, 8);
    check_eq("vram_words", io.words_done, 16'd4);
    check_eq("vram_status", io.status, 2'b00);
    for (int i = 0; i < 4; i++)
      check_eq("vram_mem", mem_rd(27'h100 + 27'(i)), pattern(27'hC00000 + 27'(i)));
    check_eq("sb_drain", exp_q.size(), 0);

    // SDRAM-like timing: late busy, long busy
    pre_dly = 3; busy_len = 10;
    push_copy(27'h200, 27'h300, 2, 0);
    run_cmd(27'h200, 27'h300, 16'd2, cyc);
    check_eq("sdram_words", io.words_done, 16'd2);
    check_eq("sdram_status", io.status, 2'b00);
    check_eq("sdram_mem", mem_rd(27'h301), pattern(27'h201));
    check_eq("sb_drain", exp_q.size(), 0);
    pre_dly = 0; busy_len = 1;

    // timeout on the second read
    hang_txn = txn_cnt + 3;
    push_copy(27'h400, 27'h500, 1, 1);
    run_cmd(27'h400, 27'h500, 16'd3, cyc);
    check_eq("tmo_status", io.status, 2'b01);
    check_eq("tmo_words", io.words_done, 16'd1);
    check_eq("tmo_hi_cycles", last_hi, TMO);
    check_eq("tmo_starts", start_cnt, 3);
    check_eq("sb_drain", exp_q.size(), 0);
    hang_txn = -1;

    // abort pulsed during the read of word index 2
    base = txn_cnt;
    push_copy(27'h600, 27'h700, 3, 0);
    fork
      run_cmd(27'h600, 27'h700, 16'd5, cyc);
      begin
        for (int i = 0; i < 100 && txn_cnt != base + 5; i++) @(negedge clk);
        check_eq("abort_reached", txn_cnt, base + 5);
        io.abort = 1'b1;
        @(negedge clk);
        io.abort = 1'b0;
      end
    join
    check_eq("abort_status", io.status, 2'b10);
    check_eq("abort_words", io.words_done, 16'd3);
    check_eq("abort_starts", start_cnt, 6);
    check_eq("abort_mem", mem_rd(27'h702), pattern(27'h602));
    check_eq("sb_drain", exp_q.size(), 0);

    // reset asserted during the first write
    base = txn_cnt;
    push_copy(27'h800, 27'h900, 3, 0);
    @(negedge clk);
    io.cmd_src = 27'h800; io.cmd_dst = 27'h900; io.cmd_len = 16'd3;
    io.cmd_valid = 1'b1;
    @(negedge clk);
    io.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && txn_cnt != base + 2; i++) @(negedge clk);
    check_eq("rstw_reached", txn_cnt, base + 2);
    check_eq("rstw_in_write", io.bus_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("rstw_start", io.bus_start, 1'b0);
    check_eq("rstw_we", io.bus_we, 1'b0);
    check_eq("rstw_words", io.words_done, 16'd0);
    check_eq("rstw_status", io.status, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("rstw_ready", io.cmd_ready, 1'b1);
    push_copy(27'hA00, 27'hB00, 1, 0);
    run_cmd(27'hA00, 27'hB00, 16'd1, cyc);
    check_eq("post_rst_status", io.status, 2'b00);
    check_eq("post_rst_words", io.words_done, 16'd1);
    check_eq("post_rst_mem", mem_rd(27'hB00), pattern(27'hA00));
    check_eq("sb_drain", exp_q.size(), 0);

    // source address wraps past the top of the 27-bit map
    push_copy(27'h7FFFFFE, 27'h1000, 3, 0);
    run_cmd(27'h7FFFFFE, 27'h1000, 16'd3, cyc);
    check_eq("wrap_words", io.words_done, 16'd3);
    check_eq("wrap_mem", mem_rd(27'h1002), pattern(27'h0));
    check_eq("sb_drain", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
